// File: rtl/mem_arbiter.sv
// Two-master (CPU, loader) arbiter in front of one shared memory port.
// Each access runs IDLE -> ACCESS -> RESP, with a direct hand-off from RESP to a waiting master.
module mem_arbiter #(
   parameter int WIDTH = 32,
   parameter int RR_EN = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [WIDTH-1:0] cpu_addr,
   input  logic [WIDTH-1:0] cpu_wdata,
   output logic             cpu_ack,
   output logic [WIDTH-1:0] cpu_rdata,
   input  logic             ld_req,
   input  logic             ld_we,
   input  logic [WIDTH-1:0] ld_addr,
   input  logic [WIDTH-1:0] ld_wdata,
   output logic             ld_ack,
   output logic [WIDTH-1:0] ld_rdata,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             mem_read,
   output logic             mem_write,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic [1:0]       owner,
   output logic             proto_err
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_CPU  = 2'b01;
   localparam logic [1:0] OWN_LD   = 2'b10;
   localparam logic       RR       = (RR_EN != 0);

   state_t           r_state;
   logic [1:0]       r_owner;
   logic             r_we;
   logic             r_last_ld;
   logic             r_cpu_ack;
   logic             r_ld_ack;
   logic [WIDTH-1:0] r_cpu_rdata;
   logic [WIDTH-1:0] r_ld_rdata;
   logic [WIDTH-1:0] r_mem_addr;
   logic [WIDTH-1:0] r_mem_wdata;
   logic             r_mem_read;
   logic             r_mem_write;
   logic             r_proto_err;

   logic             w_pick_ld;
   logic             w_own_req;
   logic             w_hand;
   logic             w_grant;
   logic             w_grant_ld;
   logic             w_g_we;
   logic [WIDTH-1:0] w_g_addr;
   logic [WIDTH-1:0] w_g_wdata;

   // In fixed-priority mode a CPU RESP falls back to IDLE, where the CPU wins again,
   // so the loader only gets in once cpu_req is low.
   always_comb begin
      w_pick_ld  = ld_req & (~cpu_req | (RR & ~r_last_ld));
      w_own_req  = (r_owner == OWN_LD) ? ld_req : cpu_req;
      w_hand     = (r_owner == OWN_CPU) ? (ld_req & RR) : cpu_req;
      w_grant_ld = (r_state == S_RESP) ? (r_owner == OWN_CPU) : w_pick_ld;
      w_grant    = 1'b0;
      case (r_state)
         S_IDLE:  w_grant = cpu_req | ld_req;
         S_RESP:  w_grant = w_hand;
         default: w_grant = 1'b0;
      endcase
      w_g_we    = w_grant_ld ? ld_we    : cpu_we;
      w_g_addr  = w_grant_ld ? ld_addr  : cpu_addr;
      w_g_wdata = w_grant_ld ? ld_wdata : cpu_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_owner     <= OWN_NONE;
         r_we        <= 1'b0;
         r_last_ld   <= 1'b1;
         r_cpu_ack   <= 1'b0;
         r_ld_ack    <= 1'b0;
         r_cpu_rdata <= '0;
         r_ld_rdata  <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         r_cpu_ack   <= 1'b0;
         r_ld_ack    <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         if (r_state != S_IDLE && !w_own_req)
            r_proto_err <= 1'b1;
         case (r_state)
            S_IDLE, S_RESP: begin
               if (w_grant) begin
                  r_state     <= S_ACCESS;
                  r_owner     <= w_grant_ld ? OWN_LD : OWN_CPU;
                  r_last_ld   <= w_grant_ld;
                  r_we        <= w_g_we;
                  r_mem_addr  <= w_g_addr;
                  r_mem_wdata <= w_g_wdata;
                  r_mem_read  <= ~w_g_we;
                  r_mem_write <= w_g_we;
               end else begin
                  r_state <= S_IDLE;
                  r_owner <= OWN_NONE;
               end
            end
            S_ACCESS: begin
               r_state <= S_RESP;
               if (r_owner == OWN_LD) begin
                  r_ld_ack <= 1'b1;
                  if (!r_we) r_ld_rdata <= mem_rdata;
               end else begin
                  r_cpu_ack <= 1'b1;
                  if (!r_we) r_cpu_rdata <= mem_rdata;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_owner <= OWN_NONE;
            end
         endcase
      end
   end

   assign cpu_ack   = r_cpu_ack;
   assign ld_ack    = r_ld_ack;
   assign cpu_rdata = r_cpu_rdata;
   assign ld_rdata  = r_ld_rdata;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_read  = r_mem_read;
   assign mem_write = r_mem_write;
   assign owner     = r_owner;
   assign proto_err = r_proto_err;

   a_one_ack:    assert property (@(posedge clk) disable iff (reset) !(r_cpu_ack && r_ld_ack));
   a_one_strobe: assert property (@(posedge clk) disable iff (reset) !(r_mem_read && r_mem_write));

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: width of address and data on all ports.
REQ-002 Parameter RR_EN, default 1: 1 selects round-robin arbitration, 0 selects fixed CPU priority.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cpu_req, cpu_we  input  1 each  CPU access request and write-enable.
REQ-006 cpu_addr, cpu_wdata  input  WIDTH each  CPU address and write data.
REQ-007 cpu_ack  output  1  one-cycle completion pulse to the CPU.
REQ-008 cpu_rdata  output  WIDTH  CPU read data, valid while cpu_ack=1.
REQ-009 ld_req, ld_we, ld_addr, ld_wdata, ld_ack, ld_rdata: loader/debug port, with the same directions, widths and meaning as the cpu_* signals.
REQ-010 mem_addr, mem_wdata  output  WIDTH each  address and write data to the shared memory.
REQ-011 mem_read, mem_write  output  1 each  memory strobes.
REQ-012 mem_rdata  input  WIDTH  combinational read data from memory.
REQ-013 owner  output  2  current owner: 00 none, 01 CPU, 10 loader.
REQ-014 proto_err  output  1  sticky flag: a requester dropped req before ack.

Function
REQ-015 The state machine SHALL have three states: IDLE, ACCESS, RESP; the state encoding is free.
REQ-016 IDLE: if any req=1, pick a winner (REQ-020/021), latch its we/addr/wdata, set owner, go to ACCESS; otherwise stay in IDLE with owner=00.
REQ-017 ACCESS (one cycle): drive mem_addr/mem_wdata from the latched values.
  - mem_read=~we, mem_write=we.
  - Register mem_rdata into the winner's rdata at the end of the cycle.
  - Go to RESP.
REQ-018 RESP (one cycle): mem strobes SHALL be 0; the winner's ack=1; rdata is held.
REQ-019 RESP next state:
  - If the other requester's req=1, grant it directly (latch, set owner, go to ACCESS).
  - Otherwise go to IDLE.
  - The just-acked requester's req in the RESP cycle SHALL be ignored.
REQ-020 With RR_EN=1 and both req=1 in IDLE, the requester not served most recently wins; after reset the CPU wins first.
REQ-021 With RR_EN=0 and both req=1 in IDLE, the CPU always wins.
REQ-022 Latency: req first sampled in IDLE at edge N -> mem strobe during cycle N+1 -> ack during cycle N+2.
  - Single requester: one access per 3 cycles.
  - Alternating requesters: one access per 2 cycles.
REQ-023 A requester SHALL hold req/we/addr/wdata until its ack; the arbiter uses only the values latched at grant.
REQ-024 If the owner's req=0 during ACCESS or RESP:
  - proto_err SHALL set and stay at 1 until reset.
  - The access SHALL still complete and ack SHALL still pulse.
REQ-025 At most one ack SHALL be 1 in any cycle, and at most one of mem_read/mem_write SHALL be 1 in any cycle.
REQ-026 rdata of the non-owner SHALL be held unchanged; a write access SHALL NOT modify the writer's rdata.
REQ-027 A req still high in the cycle after ack SHALL be a new request.

Reset
REQ-028 Assertion of reset SHALL take effect immediately, with no clock edge required. It SHALL force:
  - state IDLE, owner=00;
  - mem_read=0, mem_write=0;
  - cpu_ack=0, ld_ack=0;
  - mem_addr, mem_wdata, cpu_rdata, ld_rdata = 0;
  - proto_err=0;
  - round-robin pointer = CPU-first.
REQ-029 Reset mid-access SHALL abort the access: no ack is issued, and the aborted request SHALL be re-arbitrated after reset release if its req is still high.
REQ-030 The first grant SHALL be at the first rising edge after reset deasserts.

Verification
REQ-031 CPU read of addr 0x10, memory returns 0x1234ABCD:
  - mem_read=1 at cycle N+1.
  - cpu_ack=1 with cpu_rdata=0x1234ABCD at cycle N+2.
  - ld_ack=0 throughout.
REQ-032 Loader write of 0xDEADBEEF to 0x40:
  - mem_write=1, mem_addr=0x40, mem_wdata=0xDEADBEEF for exactly one cycle.
  - ld_ack pulses the next cycle.
  - ld_rdata is unchanged.
REQ-033 Both req=1 continuously, RR_EN=1:
  - owner sequence is 01,10,01,10,...
  - acks alternate every 2 cycles.
REQ-034 Both req=1 continuously, RR_EN=0:
  - CPU acked at cycles 2,5,8,...
  - loader is starved while cpu_req stays 1.
  - loader is served within 2 cycles of cpu_req falling.
REQ-035 Reset asserted between clock edges during ACCESS:
  - mem strobes drop to 0 immediately, and no ack pulses.
  - After release with req still high, the access completes 2 cycles after the first grant.
REQ-036 CPU drops cpu_req during ACCESS:
  - proto_err=1 and stays 1.
  - cpu_ack still pulses once.
  - Only reset clears proto_err.
